// File: rtl/vfm_input_conditioner.sv
// vfm_input_conditioner: synchronizes and debounces board switches, emitting one In0 write strobe per clean press
module vfm_input_conditioner #(
   parameter int DATA_W          = 14,
   parameter int SW_W            = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int PULSE_CYCLES    = 1
) (
   input  logic              Clock_pin,
   input  logic              Reset_pin,
   input  logic [SW_W:0]     SW_in,
   output logic [DATA_W-1:0] Data_out,
   output logic              Write_out,
   output logic [SW_W:0]     Sw_stable,
   output logic [7:0]        Strobe_count
);
   localparam int PW = $clog2(PULSE_CYCLES) + 1;
   typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} state_t;
   state_t state, state_nx;
   logic [SW_W:0] sync1, sync2, deb, deb_prev;
   logic [CNT_W-1:0] cnt [SW_W:0];
   logic [PW-1:0] pcnt;
   logic capture;
   assign Sw_stable = deb;
   always_ff @(posedge Clock_pin or posedge Reset_pin)
      if (Reset_pin) begin
         sync1    <= '0;
         sync2    <= '0;
         deb_prev <= '0;
      end else begin
         sync1    <= SW_in;
         sync2    <= sync1;
         deb_prev <= deb;
      end
   // any return to the accepted level restarts that bit's count
   always_ff @(posedge Clock_pin or posedge Reset_pin)
      if (Reset_pin) begin
         deb <= '0;
         for (int i = 0; i <= SW_W; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i <= SW_W; i++)
            if (sync2[i] == deb[i]) cnt[i] <= '0;
            else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + CNT_W'(1);
      end
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      unique case (state)
         IDLE:     if (deb[SW_W] && !deb_prev[SW_W]) begin
                      state_nx = PULSE;
                      capture  = 1'b1;
                   end
         PULSE:    if (pcnt == PW'(PULSE_CYCLES - 1)) state_nx = WAIT_REL;
         WAIT_REL: if (!deb[SW_W]) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end
   always_ff @(posedge Clock_pin or posedge Reset_pin)
      if (Reset_pin) begin
         state        <= IDLE;
         pcnt         <= '0;
         Write_out    <= 1'b0;
         Data_out     <= '0;
         Strobe_count <= '0;
      end else begin
         state     <= state_nx;
         pcnt      <= (state == PULSE) ? pcnt + PW'(1) : '0;
         Write_out <= (state_nx == PULSE);
         if (capture) begin
            Data_out     <= DATA_W'(deb[SW_W-1:0]);
            Strobe_count <= Strobe_count + 8'd1;
         end
      end
endmodule
